// File: rtl/mc_sched_pkg.sv
// mc_sched_pkg: shared sizes, FSM state type and counter helpers for the command scheduler
package mc_sched_pkg;
  localparam int NUM_REQ = 8;
  localparam int FAW_SLOTS = 4;
  localparam int CNT_W = 8;
  localparam int IDX_W = $clog2(NUM_REQ);
  typedef enum logic {ARB, REFRESH} state_e;
  typedef logic [CNT_W-1:0] cnt_t;
  // Loading cfg-1 makes the next qualifying fire land exactly max(cfg,1) cycles later
  function automatic cnt_t load_val(cnt_t cfg);
    return (cfg == '0) ? '0 : cnt_t'(cfg - 1'b1);
  endfunction
  function automatic cnt_t dec_sat(cnt_t c);
    return (c == '0) ? '0 : cnt_t'(c - 1'b1);
  endfunction
endpackage

// File: rtl/rr_pick8.sv
// rr_pick8: round-robin picker, first set request at or above ptr with wrap, one-hot grant plus index
module rr_pick8
  import mc_sched_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx
);
  logic found;
  logic [IDX_W-1:0] j;
  always_comb begin
    gnt = '0;
    idx = '0;
    found = 1'b0;
    j = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = IDX_W'(ptr + IDX_W'(k));
      if (!found && req[j]) begin
        found = 1'b1;
        gnt[j] = 1'b1;
        idx = j;
      end
    end
  end
endmodule

// File: rtl/cmd_scheduler_b8.sv
// cmd_scheduler_b8: 8-bank command arbiter enforcing tRRD/tFAW/tCCD/WTR/RTW spacing
// with round-robin fairness and an exclusive refresh hand-off.
module cmd_scheduler_b8
  import mc_sched_pkg::*;
(
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [NUM_REQ-1:0] req_is_act,
  input  logic [NUM_REQ-1:0] req_is_read,
  input  logic [NUM_REQ-1:0] req_is_write,
  input  logic               issue_ready,
  input  logic               refresh_req,
  input  logic [CNT_W-1:0]   mul_tRRD_cfg,
  input  logic [CNT_W-1:0]   mul_tFAW_cfg,
  input  logic [CNT_W-1:0]   mul_tCCD_cfg,
  input  logic [CNT_W-1:0]   mul_WTR_LATENCY_cfg,
  input  logic [CNT_W-1:0]   mul_RTW_LATENCY_cfg,
  output logic [NUM_REQ-1:0] gnt,
  output logic               out_valid,
  output logic [IDX_W-1:0]   out_idx,
  output logic               out_is_act,
  output logic               out_is_read,
  output logic               out_is_write,
  output logic               refresh_gnt
);
  state_e state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  cnt_t trrd_q, trrd_d, tccd_q, tccd_d, wtr_q, wtr_d, rtw_q, rtw_d;
  cnt_t [FAW_SLOTS-1:0] faw_q, faw_d;
  logic [NUM_REQ-1:0] kind_act, kind_read, kind_write, elig, cand;
  logic faw_free, faw_taken, fire, fire_act, fire_read, fire_write;
  // A request with several kind bits set is treated as ACT, then READ, then WRITE
  always_comb begin
    kind_act = req_is_act;
    kind_read = req_is_read & ~req_is_act;
    kind_write = req_is_write & ~req_is_act & ~req_is_read;
    faw_free = 1'b0;
    for (int s = 0; s < FAW_SLOTS; s++) faw_free = faw_free | (faw_q[s] == '0);
    elig = (kind_act & {NUM_REQ{trrd_q == '0 && faw_free}})
         | (kind_read & {NUM_REQ{tccd_q == '0 && wtr_q == '0}})
         | (kind_write & {NUM_REQ{tccd_q == '0 && rtw_q == '0}})
         | ~(kind_act | kind_read | kind_write);
    cand = (state_q == ARB && !refresh_req) ? (req_valid & elig) : '0;
  end
  rr_pick8 u_pick (
    .req(cand),
    .ptr(rr_ptr_q),
    .gnt(gnt),
    .idx(out_idx)
  );
  assign out_valid = |gnt;
  assign out_is_act = |(gnt & kind_act);
  assign out_is_read = |(gnt & kind_read);
  assign out_is_write = |(gnt & kind_write);
  assign refresh_gnt = (state_q == REFRESH);
  assign fire = out_valid & issue_ready;
  assign fire_act = fire & out_is_act;
  assign fire_read = fire & out_is_read;
  assign fire_write = fire & out_is_write;
  always_comb begin
    state_d = refresh_req ? REFRESH : ARB;
    rr_ptr_d = fire ? IDX_W'(out_idx + 1'b1) : rr_ptr_q;
    trrd_d = fire_act ? load_val(mul_tRRD_cfg) : dec_sat(trrd_q);
    tccd_d = (fire_read || fire_write) ? load_val(mul_tCCD_cfg) : dec_sat(tccd_q);
    wtr_d = fire_write ? load_val(mul_WTR_LATENCY_cfg) : dec_sat(wtr_q);
    rtw_d = fire_read ? load_val(mul_RTW_LATENCY_cfg) : dec_sat(rtw_q);
    faw_taken = 1'b0;
    for (int s = 0; s < FAW_SLOTS; s++) begin
      faw_d[s] = dec_sat(faw_q[s]);
      if (fire_act && !faw_taken && faw_q[s] == '0) begin
        faw_d[s] = load_val(mul_tFAW_cfg);
        faw_taken = 1'b1;
      end
    end
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ARB;
      rr_ptr_q <= '0;
      trrd_q <= '0;
      tccd_q <= '0;
      wtr_q <= '0;
      rtw_q <= '0;
      faw_q <= '0;
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      trrd_q <= trrd_d;
      tccd_q <= tccd_d;
      wtr_q <= wtr_d;
      rtw_q <= rtw_d;
      faw_q <= faw_d;
    end
  end
endmodule

// File: tb/tb_cmd_scheduler_b8.sv
// tb_cmd_scheduler_b8: timestamp-based reference model checked every cycle, plus directed
// scenarios with literal expectations and a randomized soak.
module tb_cmd_scheduler_b8;
  logic sys_clk = 1'b0;
  logic sys_rst_n;
  logic [7:0] req_valid, req_is_act, req_is_read, req_is_write;
  logic issue_ready, refresh_req;
  logic [7:0] trrd_cfg, tfaw_cfg, tccd_cfg, wtr_cfg, rtw_cfg;
  logic [7:0] gnt;
  logic out_valid;
  logic [2:0] out_idx;
  logic out_is_act, out_is_read, out_is_write, refresh_gnt;
  int checks = 0;
  int failures = 0;

  always #5 sys_clk = ~sys_clk;

  cmd_scheduler_b8 dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .req_valid(req_valid), .req_is_act(req_is_act), .req_is_read(req_is_read),
    .req_is_write(req_is_write), .issue_ready(issue_ready), .refresh_req(refresh_req),
    .mul_tRRD_cfg(trrd_cfg), .mul_tFAW_cfg(tfaw_cfg), .mul_tCCD_cfg(tccd_cfg),
    .mul_WTR_LATENCY_cfg(wtr_cfg), .mul_RTW_LATENCY_cfg(rtw_cfg),
    .gnt(gnt), .out_valid(out_valid), .out_idx(out_idx), .out_is_act(out_is_act),
    .out_is_read(out_is_read), .out_is_write(out_is_write), .refresh_gnt(refresh_gnt)
  );

  // Model: a command is legal once enough cycles have passed since the relevant earlier fires
  longint now = 0;
  longint last_act, last_cas, last_wr, last_rd;
  longint act_hist[$];
  int ptr;
  bit prev_ref;
  longint fire_t[$];
  int fire_i[$];
  int pick, j;
  logic [7:0] exp_gnt;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void model_clear();
    last_act = -1000; last_cas = -1000; last_wr = -1000; last_rd = -1000;
    act_hist.delete();
    ptr = 0;
    prev_ref = 1'b0;
  endfunction

  function automatic longint mx1(logic [7:0] c);
    return (c == 8'd0) ? 1 : longint'(c);
  endfunction

  function automatic bit elig(int i);
    int busy;
    busy = 0;
    if (req_is_act[i]) begin
      foreach (act_hist[k]) if (now - act_hist[k] < mx1(tfaw_cfg)) busy++;
      return (now - last_act >= mx1(trrd_cfg)) && busy < 4;
    end
    if (req_is_read[i]) return (now - last_cas >= mx1(tccd_cfg)) && (now - last_wr >= mx1(wtr_cfg));
    if (req_is_write[i]) return (now - last_cas >= mx1(tccd_cfg)) && (now - last_rd >= mx1(rtw_cfg));
    return 1'b1;
  endfunction

  always @(negedge sys_clk) begin
    if (!sys_rst_n) model_clear();
    pick = -1;
    if (!prev_ref && !refresh_req)
      for (int k = 0; k < 8; k++) begin
        j = (ptr + k) % 8;
        if (pick < 0 && req_valid[j] && elig(j)) pick = j;
      end
    exp_gnt = (pick < 0) ? 8'h00 : (8'h01 << pick);
    chk("gnt", gnt, exp_gnt);
    chk("out_valid", out_valid, pick >= 0);
    chk("refresh_gnt", refresh_gnt, prev_ref);
    if (pick >= 0) begin
      chk("out_idx", out_idx, pick);
      chk("out_kind", {out_is_act, out_is_read, out_is_write},
          {req_is_act[pick], req_is_read[pick], req_is_write[pick]});
    end else chk("out_kind_idle", {out_is_act, out_is_read, out_is_write}, 0);
    if (sys_rst_n && out_valid && issue_ready) begin
      fire_t.push_back(now);
      fire_i.push_back(int'(out_idx));
    end
    if (sys_rst_n) begin
      if (pick >= 0 && issue_ready) begin
        if (req_is_act[pick]) begin last_act = now; act_hist.push_back(now); end
        else if (req_is_read[pick]) begin last_cas = now; last_rd = now; end
        else if (req_is_write[pick]) begin last_cas = now; last_wr = now; end
        ptr = (pick + 1) % 8;
      end
      prev_ref = refresh_req;
      while (act_hist.size() > 0 && now - act_hist[0] > 300) void'(act_hist.pop_front());
    end
    now++;
  end

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic clr_req();
    req_valid = '0; req_is_act = '0; req_is_read = '0; req_is_write = '0;
    issue_ready = 1'b1; refresh_req = 1'b0;
  endtask

  task automatic set_cfg(input logic [7:0] rr, input logic [7:0] fw, input logic [7:0] cc,
                         input logic [7:0] wt, input logic [7:0] rt);
    trrd_cfg = rr; tfaw_cfg = fw; tccd_cfg = cc; wtr_cfg = wt; rtw_cfg = rt;
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    step();
    step();
    sys_rst_n = 1'b1;
    fire_t.delete();
    fire_i.delete();
  endtask

  initial begin
    int exp_t[6] = '{0, 4, 8, 12, 20, 24};
    int kd;
    sys_rst_n = 1'b0;
    clr_req();
    set_cfg(1, 1, 1, 1, 1);
    step();
    #1;
    chk("rst_refresh_gnt", refresh_gnt, 0);
    chk("rst_gnt", gnt, 0);

    // ACT spacing by tRRD and tFAW
    set_cfg(4, 20, 1, 1, 1);
    do_reset();
    req_valid = '1; req_is_act = '1;
    repeat (25) step();
    chk("act_count", fire_t.size(), 6);
    for (int i = 0; i < 6 && i < fire_t.size(); i++) begin
      chk("act_time", 32'(fire_t[i] - fire_t[0]), exp_t[i]);
      chk("act_bank", fire_i[i], i);
    end

    // reset in the middle of a tFAW window frees ACT immediately
    clr_req();
    set_cfg(1, 20, 1, 1, 1);
    do_reset();
    req_valid = '1; req_is_act = '1;
    repeat (6) step();
    chk("faw_fires", fire_t.size(), 4);
    chk("faw_block", out_valid, 0);
    sys_rst_n = 1'b0;
    step();
    sys_rst_n = 1'b1;
    fire_t.delete(); fire_i.delete();
    #1;
    chk("faw_after_rst_gnt", gnt, 8'h01);
    step();
    chk("faw_after_rst_fire", fire_t.size(), 1);

    // WRITE then READ waits WTR
    clr_req();
    set_cfg(1, 1, 2, 6, 1);
    do_reset();
    req_valid = 8'h02; req_is_write = 8'h02;
    step();
    req_valid = 8'h04; req_is_write = '0; req_is_read = 8'h04;
    repeat (10) step();
    chk("wtr_fires", fire_t.size() >= 2, 1);
    if (fire_t.size() >= 2) begin
      chk("wtr_gap", 32'(fire_t[1] - fire_t[0]), 6);
      chk("wtr_bank", fire_i[1], 2);
    end

    // other commands rotate 0..7 then wrap
    clr_req();
    set_cfg(1, 1, 1, 1, 1);
    do_reset();
    req_valid = '1;
    repeat (9) step();
    chk("rr_count", fire_t.size(), 9);
    for (int i = 0; i < 9 && i < fire_t.size(); i++) begin
      chk("rr_bank", fire_i[i], i % 8);
      chk("rr_time", 32'(fire_t[i] - fire_t[0]), i);
    end

    // refresh hand-off and resume from rr_ptr
    do_reset();
    req_valid = '1;
    for (int i = 0; i < 34; i++) begin
      refresh_req = (i >= 10 && i < 30);
      #1;
      if (i == 10) begin chk("ref_block_gnt", gnt, 0); chk("ref_gnt_lag", refresh_gnt, 0); end
      if (i == 11) chk("ref_gnt_on", refresh_gnt, 1);
      if (i == 30) begin chk("ref_gnt_hold", refresh_gnt, 1); chk("ref_drop_gnt", out_valid, 0); end
      if (i == 31) begin chk("ref_gnt_off", refresh_gnt, 0); chk("ref_resume_idx", out_idx, 2); end
      step();
    end

    // back-pressure holds grant without loading counters
    clr_req();
    set_cfg(10, 1, 1, 1, 1);
    do_reset();
    req_valid = 8'h08; req_is_act = 8'h08; issue_ready = 1'b0;
    repeat (5) begin
      #1;
      chk("bp_hold", gnt, 8'h08);
      step();
    end
    issue_ready = 1'b1;
    step();
    chk("bp_fire", fire_t.size(), 1);
    chk("bp_trrd_loaded", out_valid, 0);

    // randomized soak, configuration changed only while in reset
    for (int blk = 0; blk < 12; blk++) begin
      clr_req();
      sys_rst_n = 1'b0;
      set_cfg(8'($urandom_range(0, 5)), 8'($urandom_range(0, 24)), 8'($urandom_range(0, 4)),
              8'($urandom_range(0, 8)), 8'($urandom_range(0, 8)));
      step();
      sys_rst_n = 1'b1;
      repeat (250) begin
        for (int b = 0; b < 8; b++) begin
          kd = $urandom_range(0, 3);
          req_is_act[b] = (kd == 1);
          req_is_read[b] = (kd == 2);
          req_is_write[b] = (kd == 3);
        end
        req_valid = 8'($urandom);
        issue_ready = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 30) == 0) refresh_req = !refresh_req;
        sys_rst_n = ($urandom_range(0, 300) != 0);
        step();
      end
    end
    sys_rst_n = 1'b1;
    clr_req();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
